alu_sequencer: RTL

//  Micro-sequencer that drives the ALU / accumulator (Aku) / carry (Reg_CY) datapath.

---
 rtl/alu_seq_pkg.sv | 50 +++++
 rtl/alu_seq_decode.sv | 36 +++
 rtl/alu_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU micro-sequencer: ALU operation codes, opcode set,
// decoded control bundle and sequencer states.
package alu_seq_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_LD  = 3'd6;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_LD   = 4'h7,
    OP_ADC  = 4'h8,
    OP_SBC  = 4'h9,
    OP_JMP  = 4'hA,
    OP_JC   = 4'hB,
    OP_JZ   = 4'hC,
    OP_RSVD = 4'hD,
    OP_RSVE = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef struct packed {
    logic [2:0] alu_code;
    logic       a_ce;
    logic       cy_ce;
    logic       ci_sel;
    logic       jmp;
    logic       jc;
    logic       jz;
    logic       halt;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder for alu_sequencer.
// JZ decodes as a jump only when ALU_SEQ_ZFLAG_EN is defined; otherwise it is a NOP.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  opcode_t op,
  output ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD: begin ctrl.alu_code = ALU_ADD; ctrl.a_ce = 1'b1; ctrl.cy_ce = 1'b1; end
      OP_SUB: begin ctrl.alu_code = ALU_SUB; ctrl.a_ce = 1'b1; ctrl.cy_ce = 1'b1; end
      OP_AND: begin ctrl.alu_code = ALU_AND; ctrl.a_ce = 1'b1; end
      OP_OR:  begin ctrl.alu_code = ALU_OR;  ctrl.a_ce = 1'b1; end
      OP_XOR: begin ctrl.alu_code = ALU_XOR; ctrl.a_ce = 1'b1; end
      OP_NOT: begin ctrl.alu_code = ALU_NOT; ctrl.a_ce = 1'b1; end
      OP_LD:  begin ctrl.alu_code = ALU_LD;  ctrl.a_ce = 1'b1; end
      OP_ADC: begin
        ctrl.alu_code = ALU_ADD; ctrl.a_ce = 1'b1; ctrl.cy_ce = 1'b1; ctrl.ci_sel = 1'b1;
      end
      OP_SBC: begin
        ctrl.alu_code = ALU_SUB; ctrl.a_ce = 1'b1; ctrl.cy_ce = 1'b1; ctrl.ci_sel = 1'b1;
      end
      OP_JMP:  ctrl.jmp  = 1'b1;
      OP_JC:   ctrl.jc   = 1'b1;
`ifdef ALU_SEQ_ZFLAG_EN
      OP_JZ:   ctrl.jz   = 1'b1;
`endif
      OP_HALT: ctrl.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute micro-sequencer driving the ALU / Aku / Reg_CY datapath.
// Optional zero-flag jump (JZ) enabled by defining ALU_SEQ_ZFLAG_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned IMM_W = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [11:0]      imem_data,
  input  logic [IMM_W-1:0] Aku,
  input  logic             CY,
  output logic [2:0]       ALUCode,
  output logic [IMM_W-1:0] R,
  output logic             Ci,
  output logic             A_CE,
  output logic             CY_CE,
  output logic             busy,
  output logic             halted
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [11:0]       ir_q, ir_d;
  ctrl_t             ctrl;
  logic [IMM_W-1:0]  imm;
  logic              jz_take;
  logic              take_jump;

  assign imm = ir_q[IMM_W-1:0];

  alu_seq_decode u_decode (
    .op   (opcode_t'(ir_q[11:8])),
    .ctrl (ctrl)
  );

`ifdef ALU_SEQ_ZFLAG_EN
  assign jz_take = ctrl.jz & (Aku == '0);
`else
  logic unused_zflag;
  assign jz_take      = 1'b0;
  assign unused_zflag = ^{Aku, ctrl.jz};
`endif

  // Branch conditions read CY/Aku live in EXEC; the prior EXEC write has landed by then.
  assign take_jump = ctrl.jmp | (ctrl.jc & CY) | jz_take;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl.halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = take_jump ? PC_W'(imm) : pc_q + PC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_addr = pc_q;
    imem_req  = (state_q == S_FETCH);
    busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
    halted    = (state_q == S_HALT);
    ALUCode   = '0;
    R         = '0;
    Ci        = 1'b0;
    A_CE      = 1'b0;
    CY_CE     = 1'b0;
    if (state_q == S_EXEC) begin
      ALUCode = ctrl.alu_code;
      R       = imm;
      Ci      = ctrl.ci_sel & CY;
      A_CE    = ctrl.a_ce;
      CY_CE   = ctrl.cy_ce;
    end
  end

endmodule
